pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage pipeline. Each cycle it drives the per-register `stall` and `zero` controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipe registers and the PC write-hold. Its inputs are load-use hazards, taken branches, multi-cycle multiplies and memory wait. It also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush controller for the 5-stage pipeline.
// Drives per-register stall/zero controls and the PC hold from load-use,
// taken-branch, multi-cycle multiply and memory-wait conditions, and keeps a
// saturating count of PC-stall cycles for performance debug.
module pipe_hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int AW      = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] if_id_rs_i,
  input  logic [AW-1:0] if_id_rt_i,
  input  logic          if_id_uses_rt_i,
  input  logic          id_ex_memread_i,
  input  logic [AW-1:0] id_ex_rt_i,
  input  logic          id_ex_mul_i,
  input  logic          branch_taken_i,
  input  logic          mem_busy_i,
  output logic          pc_stall_o,
  output logic          if_id_stall_o,
  output logic          if_id_zero_o,
  output logic          id_ex_stall_o,
  output logic          id_ex_zero_o,
  output logic          ex_mem_stall_o,
  output logic          ex_mem_zero_o,
  output logic          mem_wb_zero_o,
  output logic [1:0]    state_o,
  output logic [15:0]   stall_cycles_o
);

  // Counter only needs to hold MUL_LAT-2; $clog2(MUL_LAT) covers that for MUL_LAT >= 2.
  localparam int CW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_WAIT = 2'd1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] mul_cnt;
  logic [CW-1:0] mul_cnt_nxt;
  logic [15:0]   stall_cnt;
  logic          load_use;

  // Load-use hazard: EX load writes a non-zero register the ID instruction reads.
  always_comb begin
    load_use = 1'b0;
    if (id_ex_memread_i && (id_ex_rt_i != {AW{1'b0}})) begin
      if ((id_ex_rt_i == if_id_rs_i) ||
          (if_id_uses_rt_i && (id_ex_rt_i == if_id_rt_i))) begin
        load_use = 1'b1;
      end else begin
        load_use = 1'b0;
      end
    end else begin
      load_use = 1'b0;
    end
  end

  // Prioritised hazard decode: reset, memory wait, multiply, branch, load-use.
  always_comb begin
    pc_stall_o     = 1'b0;
    if_id_stall_o  = 1'b0;
    if_id_zero_o   = 1'b0;
    id_ex_stall_o  = 1'b0;
    id_ex_zero_o   = 1'b0;
    ex_mem_stall_o = 1'b0;
    ex_mem_zero_o  = 1'b0;
    mem_wb_zero_o  = 1'b0;
    state_nxt      = state;
    mul_cnt_nxt    = mul_cnt;
    if (rst_i) begin
      // Bubble every pipe register while in reset.
      if_id_zero_o  = 1'b1;
      id_ex_zero_o  = 1'b1;
      ex_mem_zero_o = 1'b1;
      mem_wb_zero_o = 1'b1;
      state_nxt     = RUN;
      mul_cnt_nxt   = {CW{1'b0}};
    end else if (mem_busy_i) begin
      // Freeze everything up to EX/MEM; MEM result is not valid yet.
      pc_stall_o     = 1'b1;
      if_id_stall_o  = 1'b1;
      id_ex_stall_o  = 1'b1;
      ex_mem_stall_o = 1'b1;
      mem_wb_zero_o  = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (id_ex_mul_i) begin
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            id_ex_stall_o = 1'b1;
            ex_mem_zero_o = 1'b1;
            mul_cnt_nxt   = CW'(MUL_LAT - 2);
            state_nxt     = MUL_WAIT;
          end else if (branch_taken_i) begin
            // Flush the two wrong-path slots; the PC loads the target.
            if_id_zero_o = 1'b1;
            id_ex_zero_o = 1'b1;
          end else if (load_use) begin
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            id_ex_zero_o  = 1'b1;
          end else begin
            pc_stall_o = 1'b0;
          end
        end
        MUL_WAIT: begin
          // Multiply still owns EX, so branch and load-use are not looked at.
          if (mul_cnt != {CW{1'b0}}) begin
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            id_ex_stall_o = 1'b1;
            ex_mem_zero_o = 1'b1;
            mul_cnt_nxt   = mul_cnt - CW'(1);
          end else begin
            state_nxt = RUN;
          end
        end
        default: begin
          state_nxt   = RUN;
          mul_cnt_nxt = {CW{1'b0}};
        end
      endcase
    end
  end

  // State, multiply counter and saturating stall-cycle counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= RUN;
      mul_cnt   <= {CW{1'b0}};
      stall_cnt <= 16'd0;
    end else begin
      state   <= state_nxt;
      mul_cnt <= mul_cnt_nxt;
      if (pc_stall_o && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end else begin
        stall_cnt <= stall_cnt;
      end
    end
  end

  assign state_o        = state;
  assign stall_cycles_o = stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl (MUL_LAT = 4, AW = 5).
// Output vector packing: {pc, if_id_st, if_id_z, id_ex_st, id_ex_z, ex_mem_st, ex_mem_z, mem_wb_z}.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] if_id_rs;
  logic [4:0] if_id_rt;
  logic       if_id_uses_rt;
  logic       id_ex_memread;
  logic [4:0] id_ex_rt;
  logic       id_ex_mul;
  logic       branch_taken;
  logic       mem_busy;
  logic       pc_stall;
  logic       if_id_stall;
  logic       if_id_zero;
  logic       id_ex_stall;
  logic       id_ex_zero;
  logic       ex_mem_stall;
  logic       ex_mem_zero;
  logic       mem_wb_zero;
  logic [1:0] state;
  logic [15:0] stall_cycles;
  logic [7:0] outs;

  int checks = 0;
  int errors = 0;

  localparam logic [7:0] O_NONE  = 8'b0000_0000;
  localparam logic [7:0] O_LU    = 8'b1100_1000;
  localparam logic [7:0] O_BR    = 8'b0010_1000;
  localparam logic [7:0] O_MEM   = 8'b1101_0101;
  localparam logic [7:0] O_MUL   = 8'b1101_0010;
  localparam logic [7:0] O_RST   = 8'b0010_1011;

  pipe_hazard_ctrl #(.MUL_LAT(4), .AW(5)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .if_id_rs_i     (if_id_rs),
    .if_id_rt_i     (if_id_rt),
    .if_id_uses_rt_i(if_id_uses_rt),
    .id_ex_memread_i(id_ex_memread),
    .id_ex_rt_i     (id_ex_rt),
    .id_ex_mul_i    (id_ex_mul),
    .branch_taken_i (branch_taken),
    .mem_busy_i     (mem_busy),
    .pc_stall_o     (pc_stall),
    .if_id_stall_o  (if_id_stall),
    .if_id_zero_o   (if_id_zero),
    .id_ex_stall_o  (id_ex_stall),
    .id_ex_zero_o   (id_ex_zero),
    .ex_mem_stall_o (ex_mem_stall),
    .ex_mem_zero_o  (ex_mem_zero),
    .mem_wb_zero_o  (mem_wb_zero),
    .state_o        (state),
    .stall_cycles_o (stall_cycles)
  );

  assign outs = {pc_stall, if_id_stall, if_id_zero, id_ex_stall,
                 id_ex_zero, ex_mem_stall, ex_mem_zero, mem_wb_zero};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       memread;
    logic [4:0] ex_rt;
    logic       br;
    logic       busy;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_in();
    if_id_rs = 5'd0; if_id_rt = 5'd0; if_id_uses_rt = 1'b0;
    id_ex_memread = 1'b0; id_ex_rt = 5'd0; id_ex_mul = 1'b0;
    branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  // Wait for the next rising edge and step just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive reset for two cycles and release it with idle inputs.
  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, O_NONE};
    vecs[1]  = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, O_LU};
    vecs[2]  = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, O_NONE};
    vecs[3]  = '{5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, O_LU};
    vecs[4]  = '{5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, O_NONE};
    vecs[5]  = '{5'd9, 5'd9, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, O_NONE};
    vecs[6]  = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, O_NONE};
    vecs[7]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, O_BR};
    vecs[8]  = '{5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0, O_BR};
    vecs[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, O_MEM};
    vecs[10] = '{5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b1, O_MEM};

    // Reset with random inputs applied.
    #1;
    rst = 1'b1;
    if_id_rs = 5'($urandom); if_id_rt = 5'($urandom); if_id_uses_rt = 1'($urandom);
    id_ex_memread = 1'b1; id_ex_rt = 5'($urandom); id_ex_mul = 1'b1;
    branch_taken = 1'b1; mem_busy = 1'b1;
    @(negedge clk);
    chk("reset_outs", 32'(outs), 32'(O_RST));
    tick();
    @(negedge clk);
    chk("reset_outs2", 32'(outs), 32'(O_RST));
    tick();
    rst = 1'b0;
    clear_in();
    @(negedge clk);
    chk("post_reset_state", 32'(state), 32'd0);
    chk("post_reset_cnt", 32'(stall_cycles), 32'd0);
    chk("post_reset_outs", 32'(outs), 32'(O_NONE));

    // Load-use single bubble.
    tick();
    id_ex_memread = 1'b1; id_ex_rt = 5'd5; if_id_rs = 5'd5;
    @(negedge clk);
    chk("loaduse_outs", 32'(outs), 32'(O_LU));
    tick();
    clear_in();
    @(negedge clk);
    chk("loaduse_cnt", 32'(stall_cycles), 32'd1);
    chk("loaduse_release", 32'(outs), 32'(O_NONE));

    // No hazard on register $0.
    tick();
    id_ex_memread = 1'b1; id_ex_rt = 5'd0; if_id_rs = 5'd0;
    @(negedge clk);
    chk("zero_reg_outs", 32'(outs), 32'(O_NONE));
    tick();
    clear_in();
    @(negedge clk);
    chk("zero_reg_cnt", 32'(stall_cycles), 32'd1);

    // Table of single-cycle decodes in RUN.
    for (int i = 0; i < 11; i++) begin
      tick();
      if_id_rs = vecs[i].rs; if_id_rt = vecs[i].rt; if_id_uses_rt = vecs[i].uses_rt;
      id_ex_memread = vecs[i].memread; id_ex_rt = vecs[i].ex_rt;
      branch_taken = vecs[i].br; mem_busy = vecs[i].busy; id_ex_mul = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_outs", i), 32'(outs), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_state", i), 32'(state), 32'd0);
    end
    tick();
    clear_in();

    // Multiply, MUL_LAT = 4: three stall cycles, branch ignored in MUL_WAIT.
    do_reset();
    id_ex_mul = 1'b1;
    @(negedge clk);
    chk("mul_c0_outs", 32'(outs), 32'(O_MUL));
    chk("mul_c0_state", 32'(state), 32'd0);
    tick();
    @(negedge clk);
    chk("mul_c1_outs", 32'(outs), 32'(O_MUL));
    chk("mul_c1_state", 32'(state), 32'd1);
    tick();
    branch_taken = 1'b1;
    @(negedge clk);
    chk("mul_c2_outs_br", 32'(outs), 32'(O_MUL));
    tick();
    id_ex_mul = 1'b0;
    @(negedge clk);
    chk("mul_c3_release", 32'(outs), 32'(O_NONE));
    chk("mul_c3_state", 32'(state), 32'd1);
    tick();
    branch_taken = 1'b0;
    @(negedge clk);
    chk("mul_done_state", 32'(state), 32'd0);
    chk("mul_done_cnt", 32'(stall_cycles), 32'd3);

    // Memory wait for 2 cycles during MUL_WAIT with counter = 1.
    do_reset();
    id_ex_mul = 1'b1;
    tick();              // RUN -> MUL_WAIT, cnt 2
    tick();              // cnt 2 -> 1
    mem_busy = 1'b1;
    @(negedge clk);
    chk("mw_busy1_outs", 32'(outs), 32'(O_MEM));
    tick();
    @(negedge clk);
    chk("mw_busy2_outs", 32'(outs), 32'(O_MEM));
    chk("mw_busy2_state", 32'(state), 32'd1);
    tick();
    mem_busy = 1'b0;
    @(negedge clk);
    chk("mw_resume_outs", 32'(outs), 32'(O_MUL));
    tick();
    id_ex_mul = 1'b0;
    @(negedge clk);
    chk("mw_release_outs", 32'(outs), 32'(O_NONE));
    tick();
    @(negedge clk);
    chk("mw_state", 32'(state), 32'd0);
    chk("mw_cnt", 32'(stall_cycles), 32'd5);

    // Reset mid-multiply aborts to RUN.
    do_reset();
    id_ex_mul = 1'b1;
    tick();
    rst = 1'b1;
    id_ex_mul = 1'b0;
    @(negedge clk);
    chk("rst_mid_mul_outs", 32'(outs), 32'(O_RST));
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_mul_state", 32'(state), 32'd0);
    chk("rst_mid_mul_cnt", 32'(stall_cycles), 32'd0);

    // Saturation of the stall-cycle counter under long memory wait.
    mem_busy = 1'b1;
    for (int c = 0; c < 65540; c++) begin
      tick();
    end
    @(negedge clk);
    chk("sat_cnt", 32'(stall_cycles), 32'h0000_FFFF);
    tick();
    mem_busy = 1'b0;
    @(negedge clk);
    chk("sat_hold", 32'(stall_cycles), 32'h0000_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
